// File: rtl/boost_startup_sequencer_pkg.sv
// Shared definitions for the boost converter control peripheral and its startup sequencer.
// Register map, status bits, error encodings and the internal bus request payload.
package boost_startup_sequencer_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned VOUT_W     = 12;
  localparam int unsigned POLL_CNT_W = 13;
  localparam int unsigned WAIT_CNT_W = 24;
  localparam int unsigned ERR_W      = 2;

  // Boost peripheral register byte offsets
  localparam logic [ADDR_W-1:0] BOOST_ENABLE_OFF   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] BOOST_INIT_OFF     = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] BOOST_STATUS_OFF   = 32'h0000_0008;
  localparam logic [ADDR_W-1:0] BOOST_VIN_OFF      = 32'h0000_000C;
  localparam logic [ADDR_W-1:0] BOOST_VOUT_OFF     = 32'h0000_0010;
  localparam logic [ADDR_W-1:0] BOOST_VOUT_SET_OFF = 32'h0000_0014;

  localparam int unsigned STATUS_INIT_FINISHED_BIT = 0;

  localparam logic [STRB_W-1:0] STRB_WRITE = 4'hF;
  localparam logic [STRB_W-1:0] STRB_READ  = 4'h0;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE        = 2'd0,
    ERR_BUS_TIMEOUT = 2'd1,
    ERR_CAL_TIMEOUT = 2'd2
  } err_code_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic bus_req_t make_req(input logic              we,
                                        input logic [ADDR_W-1:0] base,
                                        input logic [ADDR_W-1:0] off,
                                        input logic [DATA_W-1:0] wdata);
    bus_req_t r;
    r.we    = we;
    r.addr  = base + off;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/boost_startup_sequencer_mem_bus_initiator.sv
// Runs one native mem bus transaction per request: registered handshake,
// forced idle gap between transactions and a bounded wait for ready.
module mem_bus_initiator
  import boost_startup_sequencer_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_timeout,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [STRB_W-1:0] o_mem_wstrb,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST =
    (BUS_TIMEOUT > 0) ? WAIT_CNT_W'(BUS_TIMEOUT - 1) : '0;

  typedef enum logic {BI_IDLE, BI_BUSY} bi_state_e;

  bi_state_e             r_state;
  logic                  r_valid;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_ack;
  logic                  r_timeout;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;

  // Returning to BI_IDLE with valid low guarantees at least one idle cycle before the next request
  always_ff @(posedge clk or negedge rst_n) begin : p_bus
    if (!rst_n) begin
      r_state    <= BI_IDLE;
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        BI_IDLE: begin
          if (i_req) begin
            r_valid    <= 1'b1;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            r_wstrb    <= i_we ? STRB_WRITE : STRB_READ;
            r_wait_cnt <= '0;
            r_state    <= BI_BUSY;
          end
        end
        BI_BUSY: begin
          if (i_mem_ready) begin
            r_valid <= 1'b0;
            r_ack   <= 1'b1;
            r_rdata <= i_mem_rdata;
            r_state <= BI_IDLE;
          end else if (r_wait_cnt >= TIMEOUT_LAST) begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= BI_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
          end
        end
        default: r_state <= BI_IDLE;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_timeout   = r_timeout;
  assign o_mem_valid = r_valid;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wstrb = r_wstrb;

endmodule

// File: rtl/boost_startup_sequencer.sv
// Autonomous bring-up and shutdown of one boost converter control peripheral:
// disable, program setpoint, calibrate and poll, then enable.
module boost_startup_sequencer
  import boost_startup_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TARGET_BASE   = 32'h0000_0000,
  parameter int unsigned       POLL_INTERVAL = 1000,
  parameter int unsigned       MAX_POLLS     = 4096,
  parameter int unsigned       BUS_TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [VOUT_W-1:0] vout_target,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [STRB_W-1:0] mem_wstrb_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ERR_W-1:0]  err_code
);

  localparam logic [WAIT_CNT_W-1:0] POLL_LAST =
    (POLL_INTERVAL > 0) ? WAIT_CNT_W'(POLL_INTERVAL - 1) : '0;
  localparam logic [POLL_CNT_W-1:0] POLL_MAX = POLL_CNT_W'(MAX_POLLS);

  localparam bus_req_t REQ_DIS  = make_req(1'b1, TARGET_BASE, BOOST_ENABLE_OFF, DATA_W'(0));
  localparam bus_req_t REQ_INIT = make_req(1'b1, TARGET_BASE, BOOST_INIT_OFF, DATA_W'(1));
  localparam bus_req_t REQ_STAT = make_req(1'b0, TARGET_BASE, BOOST_STATUS_OFF, DATA_W'(0));
  localparam bus_req_t REQ_EN   = make_req(1'b1, TARGET_BASE, BOOST_ENABLE_OFF, DATA_W'(1));

  typedef enum logic [3:0] {
    S_IDLE, S_W_DIS, S_W_VSET, S_W_INIT, S_R_STAT,
    S_POLL_WAIT, S_W_EN, S_SHUTDOWN, S_DONE, S_ERROR
  } state_e;

  state_e                r_state;
  logic                  r_req;
  bus_req_t              r_req_pl;
  logic [VOUT_W-1:0]     r_vout;
  logic [POLL_CNT_W-1:0] r_poll_cnt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_stop_pend;
  logic                  r_cal_pend;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  err_code_e             r_err_code;

  logic              w_ack;
  logic              w_timeout;
  logic [DATA_W-1:0] w_rdata;
  logic              w_stop_req;
  logic              w_status_ok;
  logic              w_unused;

  assign w_stop_req  = stop | r_stop_pend;
  assign w_status_ok = w_rdata[STATUS_INIT_FINISHED_BIT];
  assign w_unused    = ^w_rdata;

  always_ff @(posedge clk or negedge reset) begin : p_fsm
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_req_pl    <= '0;
      r_vout      <= '0;
      r_poll_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_stop_pend <= 1'b0;
      r_cal_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_req <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          // stop outranks start; it only has an effect when the converter is running
          if (stop && (r_state == S_DONE)) begin
            r_state     <= S_SHUTDOWN;
            r_req       <= 1'b1;
            r_req_pl    <= REQ_DIS;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_stop_pend <= 1'b0;
            r_cal_pend  <= 1'b0;
          end else if (start && !stop) begin
            r_state     <= S_W_DIS;
            r_req       <= 1'b1;
            r_req_pl    <= REQ_DIS;
            r_vout      <= vout_target;
            r_poll_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_stop_pend <= 1'b0;
            r_cal_pend  <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
          end
        end

        S_POLL_WAIT: begin
          if (w_stop_req) begin
            r_state  <= S_SHUTDOWN;
            r_req    <= 1'b1;
            r_req_pl <= REQ_DIS;
          end else if (r_poll_cnt >= POLL_MAX) begin
            r_state    <= S_SHUTDOWN;
            r_req      <= 1'b1;
            r_req_pl   <= REQ_DIS;
            r_cal_pend <= 1'b1;
          end else if (r_wait_cnt >= POLL_LAST) begin
            r_state  <= S_R_STAT;
            r_req    <= 1'b1;
            r_req_pl <= REQ_STAT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
          end
        end

        // Transaction states: wait for the initiator, then take the next step
        default: begin
          if (stop) begin
            r_stop_pend <= 1'b1;
          end
          if (w_timeout) begin
            r_state    <= S_ERROR;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= ERR_BUS_TIMEOUT;
          end else if (w_ack) begin
            if (r_state == S_SHUTDOWN) begin
              r_busy <= 1'b0;
              if (r_cal_pend) begin
                r_state    <= S_ERROR;
                r_error    <= 1'b1;
                r_err_code <= ERR_CAL_TIMEOUT;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (w_stop_req) begin
              r_state  <= S_SHUTDOWN;
              r_req    <= 1'b1;
              r_req_pl <= REQ_DIS;
            end else if (r_state == S_W_DIS) begin
              r_state  <= S_W_VSET;
              r_req    <= 1'b1;
              r_req_pl <= make_req(1'b1, TARGET_BASE, BOOST_VOUT_SET_OFF, DATA_W'(r_vout));
            end else if (r_state == S_W_VSET) begin
              r_state  <= S_W_INIT;
              r_req    <= 1'b1;
              r_req_pl <= REQ_INIT;
            end else if (r_state == S_W_INIT) begin
              r_state  <= S_R_STAT;
              r_req    <= 1'b1;
              r_req_pl <= REQ_STAT;
            end else if (r_state == S_R_STAT) begin
              if (w_status_ok) begin
                r_state  <= S_W_EN;
                r_req    <= 1'b1;
                r_req_pl <= REQ_EN;
              end else begin
                if (r_poll_cnt < POLL_MAX) begin
                  r_poll_cnt <= r_poll_cnt + POLL_CNT_W'(1);
                end
                r_wait_cnt <= '0;
                r_state    <= S_POLL_WAIT;
              end
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  mem_bus_initiator #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_bus (
    .clk        (clk),
    .rst_n      (reset),
    .i_req      (r_req),
    .i_we       (r_req_pl.we),
    .i_addr     (r_req_pl.addr),
    .i_wdata    (r_req_pl.wdata),
    .o_ack      (w_ack),
    .o_rdata    (w_rdata),
    .o_timeout  (w_timeout),
    .o_mem_valid(mem_valid_o),
    .i_mem_ready(mem_ready_i),
    .o_mem_addr (mem_addr_o),
    .o_mem_wdata(mem_wdata_o),
    .o_mem_wstrb(mem_wstrb_o),
    .i_mem_rdata(mem_rdata_i)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_boost_startup_sequencer.sv
// Self-checking bench for boost_startup_sequencer: behavioural mem responder with
// a transaction log, a table of bring-up vectors and hand-written corner sequences.
module tb_boost_startup_sequencer;

  localparam logic [31:0] BASE      = 32'h4000_1000;
  localparam int unsigned MAXP      = 4;
  localparam int unsigned POLL_IVAL = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] vout_target = '0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  boost_startup_sequencer #(
    .TARGET_BASE  (BASE),
    .POLL_INTERVAL(POLL_IVAL),
    .MAX_POLLS    (MAXP),
    .BUS_TIMEOUT  (255)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .stop       (stop),
    .vout_target(vout_target),
    .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned rise;
  } txn_t;

  txn_t log_q[$];
  txn_t t_rec;

  // Responder configuration (written by the stimulus only)
  int unsigned resp_delay = 0;
  int unsigned ok_at = 0;
  int unsigned stat_base = 0;
  bit          hang_en = 1'b0;
  logic [31:0] hang_addr = '0;

  // Responder state (written by the responder only)
  int unsigned cyc = 0;
  int unsigned vcnt = 0;
  int unsigned rise_cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned n_rises = 0;
  int unsigned status_reads = 0;
  int unsigned stab_viol = 0;
  int unsigned fall_viol = 0;
  int unsigned last_vlen = 0;
  int unsigned min_gap = 32'hFFFF_FFFF;
  bit          seen_fall = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  bit          armed = 1'b1;
  logic [67:0] snap = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Responder: ready is one cycle wide, raised resp_delay cycles after valid rises
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_valid_o) begin
      if (!prev_valid) begin
        n_rises  = n_rises + 1;
        vcnt     = 0;
        rise_cyc = cyc;
        snap     = {mem_addr_o, mem_wdata_o, mem_wstrb_o};
        if (seen_fall && (cyc - fall_cyc) < min_gap) min_gap = cyc - fall_cyc;
      end else if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} != snap) begin
        stab_viol = stab_viol + 1;
      end
      if (prev_ready) fall_viol = fall_viol + 1;
      vcnt = vcnt + 1;
      if (armed && vcnt > resp_delay && !(hang_en && mem_addr_o == hang_addr)) begin
        mem_ready_i = 1'b1;
        armed       = 1'b0;
        mem_rdata_i = 32'h0;
        if (mem_addr_o == BASE + 32'd8 && mem_wstrb_o == 4'h0) begin
          status_reads = status_reads + 1;
          mem_rdata_i  = 32'hA5A5_A5A4;
          if (ok_at != 0 && (status_reads - stat_base) >= ok_at) mem_rdata_i[0] = 1'b1;
        end
        t_rec.addr  = mem_addr_o;
        t_rec.wdata = mem_wdata_o;
        t_rec.wstrb = mem_wstrb_o;
        t_rec.rise  = rise_cyc;
        log_q.push_back(t_rec);
      end else begin
        mem_ready_i = 1'b0;
      end
    end else begin
      if (prev_valid) begin
        fall_cyc  = cyc;
        seen_fall = 1'b1;
        last_vlen = vcnt;
      end
      armed       = 1'b1;
      mem_ready_i = 1'b0;
    end
    prev_ready = mem_ready_i;
    prev_valid = mem_valid_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(mem_valid_o), 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_wdata"}, mem_wdata_o, 0);
    check({tag, "_wstrb"}, 32'(mem_wstrb_o), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_errcode"}, 32'(err_code), 0);
  endtask

  typedef struct {
    logic [11:0] vout;
    int unsigned ok_at;
    int unsigned delay;
    bit          exp_done;
    bit          exp_err;
    logic [1:0]  exp_code;
    int unsigned exp_reads;
    int unsigned exp_vlen;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned base;
    int unsigned n_exp;
    int unsigned rises0;
    int unsigned min_sp;
    int unsigned last_rd;
    int unsigned n;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    string       nm;

    vecs[0] = '{12'h7D0, 3, 0, 1'b1, 1'b0, 2'd0, 3, 0};
    vecs[1] = '{12'hFFF, 1, 5, 1'b1, 1'b0, 2'd0, 1, 6};
    vecs[2] = '{12'h000, 4, 2, 1'b1, 1'b0, 2'd0, 4, 0};
    vecs[3] = '{12'h123, 0, 1, 1'b0, 1'b1, 2'd2, 4, 0};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Bring-up vectors
    for (int v = 0; v < 4; v++) begin
      resp_delay  = vecs[v].delay;
      ok_at       = vecs[v].ok_at;
      stat_base   = status_reads;
      base        = log_q.size();
      vout_target = vecs[v].vout;
      pulse_start();
      wait_idle(20000, $sformatf("v%0d", v));
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_errcode", v), 32'(err_code), 32'(vecs[v].exp_code));
      n_exp = 3 + vecs[v].exp_reads + 1;
      check($sformatf("v%0d_ntxn", v), log_q.size() - base, n_exp);
      min_sp  = 32'hFFFF_FFFF;
      last_rd = 0;
      for (int i = 0; i < int'(n_exp); i++) begin
        if (i == 0) begin
          e_we = 1'b1; e_addr = BASE; e_data = 32'd0;
        end else if (i == 1) begin
          e_we = 1'b1; e_addr = BASE + 32'd20; e_data = {20'b0, vecs[v].vout};
        end else if (i == 2) begin
          e_we = 1'b1; e_addr = BASE + 32'd4; e_data = 32'd1;
        end else if (i < 3 + int'(vecs[v].exp_reads)) begin
          e_we = 1'b0; e_addr = BASE + 32'd8; e_data = 32'd0;
        end else begin
          e_we = 1'b1; e_addr = BASE; e_data = {31'b0, vecs[v].exp_done};
        end
        if (base + i < log_q.size()) begin
          nm = $sformatf("v%0d_t%0d", v, i);
          check({nm, "_addr"}, log_q[base+i].addr, e_addr);
          check({nm, "_wstrb"}, 32'(log_q[base+i].wstrb), e_we ? 32'hF : 32'h0);
          if (e_we) check({nm, "_wdata"}, log_q[base+i].wdata, e_data);
          if (!e_we) begin
            if (last_rd != 0 && (log_q[base+i].rise - last_rd) < min_sp)
              min_sp = log_q[base+i].rise - last_rd;
            last_rd = log_q[base+i].rise;
          end
        end
      end
      if (vecs[v].exp_reads > 1)
        check($sformatf("v%0d_poll_spacing_ge_%0d", v, POLL_IVAL), 32'(min_sp >= POLL_IVAL), 32'd1);
      if (vecs[v].exp_vlen != 0)
        check($sformatf("v%0d_valid_len", v), last_vlen, vecs[v].exp_vlen);
    end

    // Bus timeout on the setpoint write
    resp_delay = 0;
    ok_at      = 1;
    hang_en    = 1'b1;
    hang_addr  = BASE + 32'd20;
    base       = log_q.size();
    rises0     = n_rises;
    pulse_start();
    wait_idle(2000, "bto");
    check("bto_error", 32'(error), 1);
    check("bto_errcode", 32'(err_code), 1);
    check("bto_done", 32'(done), 0);
    check("bto_valid", 32'(mem_valid_o), 0);
    check("bto_valid_len", last_vlen, 255);
    check("bto_ntxn", log_q.size() - base, 1);
    check("bto_rises", n_rises - rises0, 2);
    repeat (300) @(negedge clk);
    check("bto_no_more_rises", n_rises - rises0, 2);
    check("bto_busy_after", 32'(busy), 0);
    hang_en = 1'b0;

    // Stop while waiting between status polls
    ok_at     = 0;
    stat_base = status_reads;
    base      = log_q.size();
    pulse_start();
    n = 0;
    while ((log_q.size() - base) < 4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    pulse_stop();
    wait_idle(2000, "spoll");
    check("spoll_ntxn", log_q.size() - base, 5);
    if (log_q.size() > base + 4) begin
      check("spoll_last_addr", log_q[base+4].addr, BASE);
      check("spoll_last_wstrb", 32'(log_q[base+4].wstrb), 32'hF);
      check("spoll_last_wdata", log_q[base+4].wdata, 0);
    end
    check("spoll_done", 32'(done), 0);
    check("spoll_error", 32'(error), 0);
    check("spoll_errcode", 32'(err_code), 0);

    // Stop while running
    ok_at     = 1;
    stat_base = status_reads;
    pulse_start();
    wait_idle(5000, "sdone_up");
    check("sdone_up_done", 32'(done), 1);
    base = log_q.size();
    pulse_stop();
    wait_idle(2000, "sdone");
    check("sdone_ntxn", log_q.size() - base, 1);
    if (log_q.size() > base) begin
      check("sdone_addr", log_q[base].addr, BASE);
      check("sdone_wdata", log_q[base].wdata, 0);
    end
    check("sdone_done", 32'(done), 0);
    check("sdone_error", 32'(error), 0);

    // start and stop together while running: stop wins
    stat_base = status_reads;
    pulse_start();
    wait_idle(5000, "both_up");
    check("both_up_done", 32'(done), 1);
    base = log_q.size();
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    wait_idle(2000, "both");
    repeat (50) @(negedge clk);
    check("both_ntxn", log_q.size() - base, 1);
    if (log_q.size() > base) check("both_wdata", log_q[base].wdata, 0);
    check("both_done", 32'(done), 0);
    check("both_busy", 32'(busy), 0);

    // Asynchronous reset in the middle of a write, then a full replay
    resp_delay = 5;
    stat_base  = status_reads;
    pulse_start();
    n = 0;
    while (!mem_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("arst_mid_valid", 32'(mem_valid_o), 1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("arst");
    @(negedge clk) rst_n = 1'b1;
    stat_base   = status_reads;
    base        = log_q.size();
    vout_target = 12'h456;
    pulse_start();
    wait_idle(5000, "replay");
    check("replay_ntxn", log_q.size() - base, 5);
    if (log_q.size() > base + 1) begin
      check("replay_t0_addr", log_q[base].addr, BASE);
      check("replay_t0_wdata", log_q[base].wdata, 0);
      check("replay_t1_addr", log_q[base+1].addr, BASE + 32'd20);
      check("replay_t1_wdata", log_q[base+1].wdata, 32'h456);
    end
    check("replay_done", 32'(done), 1);

    // Handshake invariants over the whole run
    check("hs_stable_while_valid", stab_viol, 0);
    check("hs_valid_falls_after_ready", fall_viol, 0);
    check("hs_min_idle_gap_ge_1", 32'(min_gap >= 1), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
